instr_fetch_unit: RTL and testbench

//  Fetch stage ahead of the decode/register-read stage. Issues word reads to
//  a variable-latency instruction memory via req/ack and buffers returned
//  {pc, instr} pairs in a DEPTH-entry prefetch FIFO.

---
 rtl/instr_fetch_unit_pkg.sv | 29 ++
 rtl/instr_fetch_unit_if.sv | 25 ++
 rtl/instr_fetch_unit_fifo.sv | 71 +++++++
 rtl/instr_fetch_unit.sv | 127 ++++++++++++
 tb/tb_instr_fetch_unit.sv | 277 +++++++++++++++++++++++++++
 5 files changed

// File: rtl/instr_fetch_unit_pkg.sv
// Shared types and constants for the instruction fetch stage.
package instr_fetch_unit_pkg;

    localparam int unsigned XLEN          = 32;
    localparam int unsigned INSTR_W       = 32;
    localparam int unsigned DEPTH_DEFAULT = 4;
    localparam logic [XLEN-1:0] RESET_PC_DEFAULT = 32'h0000_0000;

    // Fetch sequencer states
    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_REQ  = 2'd1,
        ST_DROP = 2'd2
    } fetch_state_e;

    // One prefetch FIFO entry
    typedef struct packed {
        logic [XLEN-1:0]    pc;
        logic [INSTR_W-1:0] instr;
    } fetch_entry_t;

    localparam int unsigned ENTRY_W = $bits(fetch_entry_t);

    // Clear the byte offset of an address
    function automatic logic [XLEN-1:0] word_align(input logic [XLEN-1:0] addr);
        return addr & ~XLEN'(3);
    endfunction

endpackage

// File: rtl/instr_fetch_unit_if.sv
// Memory request/ack bus plus decode valid/ready handshake.
interface instr_fetch_unit_if;
    import instr_fetch_unit_pkg::*;

    logic                mem_req;
    logic [XLEN-1:0]     mem_addr;
    logic                mem_ack;
    logic [INSTR_W-1:0]  mem_rdata;
    logic                instr_valid;
    logic                instr_ready;
    logic [INSTR_W-1:0]  instr;
    logic [XLEN-1:0]     pc;
    logic [XLEN-1:0]     pc_plus4;

    modport master (
        output mem_req, mem_addr, instr_valid, instr, pc, pc_plus4,
        input  mem_ack, mem_rdata, instr_ready
    );

    modport slave (
        input  mem_req, mem_addr, instr_valid, instr, pc, pc_plus4,
        output mem_ack, mem_rdata, instr_ready
    );

endinterface

// File: rtl/instr_fetch_unit_fifo.sv
// Prefetch FIFO; flush wins over push and pop, push when full is taken if a pop frees a slot.
module instr_fetch_unit_fifo #(
    parameter  int unsigned WIDTH = 64,
    parameter  int unsigned DEPTH = 4,
    localparam int unsigned PTR_W = $clog2(DEPTH),
    localparam int unsigned CNT_W = $clog2(DEPTH + 1)
) (
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic             push_i,
    input  logic             pop_i,
    input  logic             flush_i,
    input  logic [WIDTH-1:0] din_i,
    output logic [WIDTH-1:0] dout_o,
    output logic             full_o,
    output logic             empty_o,
    output logic [CNT_W-1:0] count_o
);

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
    logic [CNT_W-1:0] count_q, count_d;
    logic             do_push, do_pop;

    assign full_o  = (count_q == CNT_W'(DEPTH));
    assign empty_o = (count_q == '0);
    assign count_o = count_q;
    assign dout_o  = mem_q[rd_ptr_q];
    assign do_pop  = pop_i & ~empty_o;
    assign do_push = push_i & (~full_o | do_pop);

    // Pointer and occupancy update
    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (flush_i) begin
            wr_ptr_d = '0;
            rd_ptr_d = '0;
            count_d  = '0;
        end else begin
            if (do_push) wr_ptr_d = wr_ptr_q + PTR_W'(1);
            if (do_pop)  rd_ptr_d = rd_ptr_q + PTR_W'(1);
            count_d = count_q + CNT_W'(do_push) - CNT_W'(do_pop);
        end
    end

    // Pointer and occupancy registers
    always_ff @(posedge clk_i) begin
        if (!rst_i) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

    // Entry storage, cleared so the head reads zero after reset
    always_ff @(posedge clk_i) begin
        if (!rst_i) begin
            for (int i = 0; i < int'(DEPTH); i++) mem_q[i] <= '0;
        end else if (do_push && !flush_i) begin
            mem_q[wr_ptr_q] <= din_i;
        end
    end

endmodule

// File: rtl/instr_fetch_unit.sv
// Fetch stage: issues word reads, buffers {pc, instr}, flushes and restarts on redirect.
module instr_fetch_unit
    import instr_fetch_unit_pkg::*;
#(
    parameter logic [XLEN-1:0] RESET_PC = RESET_PC_DEFAULT,
    parameter int unsigned     DEPTH    = DEPTH_DEFAULT
) (
    input  logic                      clk_i,
    input  logic                      rst_i,
    input  logic                      redirect_i,
    input  logic [XLEN-1:0]           redirect_pc_i,
    instr_fetch_unit_if.master        bus_if
);

    localparam int unsigned CNT_W = $clog2(DEPTH + 1);

    fetch_state_e    state_q, state_d;
    logic [XLEN-1:0] fetch_pc_q, fetch_pc_d;
    logic [XLEN-1:0] mem_addr_q, mem_addr_d;
    logic            mem_req_q, mem_req_d;
    logic [XLEN-1:0] target_pc;
    logic            ack_c, pop_c, push_c;
    logic            fifo_full, fifo_empty;
    logic [CNT_W-1:0] fifo_count, count_after_push;
    fetch_entry_t    push_entry, head;
    logic [ENTRY_W-1:0] head_bits;

    assign target_pc        = word_align(redirect_pc_i);
    assign ack_c            = mem_req_q & bus_if.mem_ack;
    assign pop_c            = ~fifo_empty & bus_if.instr_ready & ~redirect_i;
    assign count_after_push = fifo_count + CNT_W'(1) - CNT_W'(pop_c);
    assign mem_req_d        = (state_d != ST_IDLE);

    // State register
    always_ff @(posedge clk_i) begin
        if (!rst_i) state_q <= ST_IDLE;
        else        state_q <= state_d;
    end

    // Next-state logic
    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE: if (!redirect_i && !fifo_full) state_d = ST_REQ;
            ST_REQ: begin
                if (ack_c) begin
                    if (redirect_i)                             state_d = ST_REQ;
                    else if (count_after_push < CNT_W'(DEPTH))  state_d = ST_REQ;
                    else                                        state_d = ST_IDLE;
                end else if (redirect_i) begin
                    state_d = ST_DROP;
                end
            end
            ST_DROP: if (ack_c) state_d = redirect_i ? ST_IDLE : ST_REQ;
            default: state_d = ST_IDLE;
        endcase
    end

    // Fetch PC, request address and FIFO push control
    always_comb begin
        fetch_pc_d = fetch_pc_q;
        mem_addr_d = mem_addr_q;
        push_c     = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (redirect_i)      fetch_pc_d = target_pc;
                else if (!fifo_full) mem_addr_d = fetch_pc_q;
            end
            ST_REQ: begin
                if (redirect_i) begin
                    fetch_pc_d = target_pc;
                    if (ack_c) mem_addr_d = target_pc;
                end else if (ack_c) begin
                    push_c     = 1'b1;
                    fetch_pc_d = fetch_pc_q + XLEN'(4);
                    mem_addr_d = fetch_pc_q + XLEN'(4);
                end
            end
            ST_DROP: begin
                if (redirect_i) fetch_pc_d = target_pc;
                else if (ack_c) mem_addr_d = fetch_pc_q;
            end
            default: ;
        endcase
    end

    // Fetch PC and memory request registers
    always_ff @(posedge clk_i) begin
        if (!rst_i) begin
            fetch_pc_q <= RESET_PC;
            mem_addr_q <= '0;
            mem_req_q  <= 1'b0;
        end else begin
            fetch_pc_q <= fetch_pc_d;
            mem_addr_q <= mem_addr_d;
            mem_req_q  <= mem_req_d;
        end
    end

    assign push_entry.pc    = mem_addr_q;
    assign push_entry.instr = bus_if.mem_rdata;

    instr_fetch_unit_fifo #(
        .WIDTH (ENTRY_W),
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk_i   (clk_i),
        .rst_i   (rst_i),
        .push_i  (push_c),
        .pop_i   (pop_c),
        .flush_i (redirect_i),
        .din_i   (push_entry),
        .dout_o  (head_bits),
        .full_o  (fifo_full),
        .empty_o (fifo_empty),
        .count_o (fifo_count)
    );

    assign head               = fetch_entry_t'(head_bits);
    assign bus_if.mem_req     = mem_req_q;
    assign bus_if.mem_addr    = mem_addr_q;
    assign bus_if.instr_valid = ~fifo_empty;
    assign bus_if.instr       = head.instr;
    assign bus_if.pc          = head.pc;
    assign bus_if.pc_plus4    = head.pc + XLEN'(4);

endmodule

// File: tb/tb_instr_fetch_unit.sv
// Bench for instr_fetch_unit: directed scenarios plus randomized traffic against a stream model.
module tb_instr_fetch_unit;
    import instr_fetch_unit_pkg::*;

    localparam int unsigned DEPTH    = 4;
    localparam logic [31:0] RESET_PC = 32'h0000_0000;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        redirect;
    logic [31:0] redirect_pc;

    instr_fetch_unit_if bus_if();

    instr_fetch_unit #(.RESET_PC(RESET_PC), .DEPTH(DEPTH)) dut (
        .clk_i         (clk),
        .rst_i         (rst_n),
        .redirect_i    (redirect),
        .redirect_pc_i (redirect_pc),
        .bus_if        (bus_if.master)
    );

    always #5 clk = ~clk;

    // Memory image: every word is a fixed hash of its address
    function automatic logic [31:0] image(input logic [31:0] a);
        return (a * 32'h9E37_79B1) ^ 32'h1357_9BDF;
    endfunction

    // Variable-latency memory: ack after mem_lat wait cycles, zero means same-cycle ack
    int unsigned mem_lat = 0;
    int unsigned wait_cnt;
    always @(posedge clk) begin
        if (!rst_n || !bus_if.mem_req || bus_if.mem_ack) wait_cnt <= 0;
        else                                             wait_cnt <= wait_cnt + 1;
    end
    always_comb begin
        bus_if.mem_ack   = bus_if.mem_req && (wait_cnt >= mem_lat);
        bus_if.mem_rdata = image(bus_if.mem_addr);
    end

    int n_assert = 0;
    int n_fail   = 0;
    int pops     = 0;
    logic [31:0] exp_pc = RESET_PC;
    logic [31:0] xfer_q[$];

    logic        s_rst, s_red, s_req, s_ack, s_valid, s_ready;
    logic [31:0] s_rpc, s_addr, s_pc, s_instr, s_p4;
    logic        p_hold = 1'b0, p_red = 1'b0;
    logic [31:0] p_addr = '0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %h, expected %h", tag, obs, exp);
        end
    endtask

    // One clock: sample what the DUT sees at the coming edge, update the stream model, advance
    task automatic cycle();
        #1;
        s_rst = rst_n;   s_red = redirect;    s_rpc = redirect_pc;
        s_req = bus_if.mem_req;  s_ack = bus_if.mem_ack;  s_addr = bus_if.mem_addr;
        s_valid = bus_if.instr_valid;  s_ready = bus_if.instr_ready;
        s_pc = bus_if.pc;  s_instr = bus_if.instr;  s_p4 = bus_if.pc_plus4;
        if (p_hold) begin
            chk("req_held", 32'(s_req), 32'd1);
            chk("addr_held", s_addr, p_addr);
        end
        if (p_red) chk("valid_after_flush", 32'(s_valid), 32'd0);
        if (!s_rst) begin
            exp_pc = RESET_PC;
        end else if (s_red) begin
            exp_pc = s_rpc & ~32'h3;
        end else if (s_valid && s_ready) begin
            chk("pop_pc", s_pc, exp_pc);
            chk("pop_instr", s_instr, image(exp_pc));
            chk("pop_pc_plus4", s_p4, exp_pc + 32'd4);
            exp_pc = exp_pc + 32'd4;
            pops++;
        end
        if (s_rst && s_req && s_ack) xfer_q.push_back(s_addr);
        p_hold = s_rst && s_req && !s_ack;
        p_addr = s_addr;
        p_red  = s_rst && s_red;
        @(negedge clk);
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        redirect = 1'b0;
        cycle();
        cycle();
        rst_n = 1'b1;
    endtask

    task automatic wait_xfers(input string tag, input int n);
        int k;
        for (k = 0; k < 60 && xfer_q.size() < n; k++) cycle();
        chk(tag, 32'(xfer_q.size() >= n), 32'd1);
    endtask

    task automatic wait_valid(input string tag);
        int k;
        for (k = 0; k < 60; k++) begin
            cycle();
            if (s_valid) break;
        end
        chk(tag, 32'(s_valid), 32'd1);
    endtask

    initial begin
        int p0;
        int k;
        rst_n = 1'b0;
        redirect = 1'b0;
        redirect_pc = '0;
        bus_if.instr_ready = 1'b1;
        @(negedge clk);

        // Reset values, then zero-wait streaming at one fetch per cycle
        mem_lat = 0;
        bus_if.instr_ready = 1'b1;
        do_reset();
        cycle();
        chk("rst_req", 32'(s_req), 32'd0);
        chk("rst_valid", 32'(s_valid), 32'd0);
        chk("rst_addr", s_addr, 32'd0);
        chk("rst_pc", s_pc, 32'd0);
        chk("rst_instr", s_instr, 32'd0);
        chk("rst_pc_plus4", s_p4, 32'd4);
        p0 = pops;
        for (int i = 1; i <= 8; i++) begin
            cycle();
            chk("t1_req", 32'(s_req), 32'd1);
            chk("t1_addr", s_addr, 32'(4 * (i - 1)));
            chk("t1_valid", 32'(s_valid), 32'(i >= 2));
        end
        chk("t1_pops", 32'(pops - p0), 32'd7);

        // Latency 3 with decode stalled: exactly DEPTH fetches, then resume at 0x10
        mem_lat = 3;
        bus_if.instr_ready = 1'b0;
        do_reset();
        xfer_q.delete();
        repeat (40) cycle();
        chk("t2_nreq", 32'(xfer_q.size()), 32'd4);
        for (int i = 0; i < 4; i++)
            if (i < xfer_q.size()) chk("t2_addr", xfer_q[i], 32'(4 * i));
        chk("t2_req_low", 32'(s_req), 32'd0);
        chk("t2_valid", 32'(s_valid), 32'd1);
        chk("t2_head_pc", s_pc, 32'd0);
        bus_if.instr_ready = 1'b1;
        xfer_q.delete();
        p0 = pops;
        wait_xfers("t2_resume_seen", 1);
        if (xfer_q.size() > 0) chk("t2_resume_addr", xfer_q[0], 32'h10);
        chk("t2_pops", 32'(pops - p0), 32'd4);

        // Redirect while the 0x8 request is outstanding
        mem_lat = 2;
        bus_if.instr_ready = 1'b1;
        do_reset();
        for (k = 0; k < 50; k++) begin
            if (bus_if.mem_req && bus_if.mem_addr == 32'h8 && wait_cnt == 0) break;
            cycle();
        end
        chk("t3_found_req8", 32'(k < 50), 32'd1);
        redirect = 1'b1;
        redirect_pc = 32'h0000_0043;
        xfer_q.delete();
        cycle();
        redirect = 1'b0;
        wait_xfers("t3_xfers", 2);
        if (xfer_q.size() >= 2) begin
            chk("t3_dropped_addr", xfer_q[0], 32'h8);
            chk("t3_next_addr", xfer_q[1], 32'h40);
        end
        wait_valid("t3_valid_seen");
        chk("t3_first_pc", s_pc, 32'h40);

        // Redirect in the same cycle as an ack and a pop
        mem_lat = 1;
        bus_if.instr_ready = 1'b0;
        repeat (4) cycle();
        bus_if.instr_ready = 1'b1;
        for (k = 0; k < 20; k++) begin
            if (bus_if.mem_ack && bus_if.instr_valid) break;
            cycle();
        end
        chk("t4_found_ack_pop", 32'(k < 20), 32'd1);
        redirect = 1'b1;
        redirect_pc = 32'h0000_0080;
        p0 = pops;
        cycle();
        redirect = 1'b0;
        chk("t4_pop_ignored", 32'(pops - p0), 32'd0);
        xfer_q.delete();
        cycle();
        chk("t4_valid_low", 32'(s_valid), 32'd0);
        wait_xfers("t4_xfers", 1);
        if (xfer_q.size() > 0) chk("t4_next_addr", xfer_q[0], 32'h80);
        wait_valid("t4_valid_seen");
        chk("t4_first_pc", s_pc, 32'h80);

        // Near-full FIFO with simultaneous push and pop
        mem_lat = 0;
        bus_if.instr_ready = 1'b0;
        for (k = 0; k < 30; k++) begin
            if (!bus_if.mem_req && bus_if.instr_valid) break;
            cycle();
        end
        chk("t5_filled", 32'(k < 30), 32'd1);
        p0 = pops;
        for (int i = 0; i < 16; i++) begin
            bus_if.instr_ready = logic'(i % 2);
            cycle();
            chk("t5_valid", 32'(s_valid), 32'd1);
        end
        chk("t5_pops", 32'(pops - p0), 32'd8);

        // Reset in the middle of a long memory wait
        mem_lat = 5;
        bus_if.instr_ready = 1'b1;
        do_reset();
        repeat (3) cycle();
        chk("t6_req_pending", 32'(s_req), 32'd1);
        rst_n = 1'b0;
        cycle();
        rst_n = 1'b1;
        cycle();
        chk("t6_req_dropped", 32'(s_req), 32'd0);
        chk("t6_valid_low", 32'(s_valid), 32'd0);
        mem_lat = 0;
        xfer_q.delete();
        wait_xfers("t6_xfers", 1);
        if (xfer_q.size() > 0) chk("t6_restart_addr", xfer_q[0], RESET_PC);
        wait_valid("t6_valid_seen");
        chk("t6_first_pc", s_pc, RESET_PC);

        // Fetch PC wraps through zero
        redirect = 1'b1;
        redirect_pc = 32'hFFFF_FFF8;
        cycle();
        redirect = 1'b0;
        p0 = pops;
        repeat (8) cycle();
        chk("wrap_pops", 32'(pops - p0 >= 4), 32'd1);

        // Randomized latency, back-pressure, redirects and occasional reset
        p0 = pops;
        for (int i = 0; i < 800; i++) begin
            mem_lat = $urandom_range(0, 3);
            bus_if.instr_ready = ($urandom_range(0, 3) != 0);
            redirect = ($urandom_range(0, 19) == 0);
            if ($urandom_range(0, 3) == 0) redirect_pc = 32'hFFFF_FFF0 | 32'($urandom_range(0, 15));
            else                           redirect_pc = $urandom & 32'h0000_0FFF;
            rst_n = ($urandom_range(0, 199) != 0);
            cycle();
        end
        redirect = 1'b0;
        rst_n = 1'b1;
        chk("rand_activity", 32'(pops - p0 > 100), 32'd1);

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish, observed timeout, expected completion");
        $fatal(1);
    end

endmodule
